// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART transmitter arbiter.
package uart_tx_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARB   = 2'd1,
      XFER  = 2'd2,
      DRAIN = 2'd3
   } arb_state_e;

   localparam int CNT_W           = 16;
   localparam int DEF_N_REQ       = 4;
   localparam int DEF_MAX_PKT_LEN = 256;
   localparam int DEF_TIMEOUT_CYC = 4096;

endpackage : uart_tx_arb_pkg

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, with wrap.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int PTR_W = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [PTR_W-1:0] idx_o,
   output logic             found_o
);

   always_comb begin
      int k;
      // NOTE: every output gets a default before the search so no path leaves a latch.
      grant_o = '0;
      idx_o   = '0;
      found_o = 1'b0;
      k       = 0;
      for (int i = 0; i < N_REQ; i++) begin
         k = (int'(ptr_i) + i) % N_REQ;
         if (!found_o && req_i[k]) begin
            found_o    = 1'b1;
            grant_o[k] = 1'b1;
            idx_o      = k[PTR_W-1:0];
         end
      end
   end

endmodule : rr_pick

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART transmitter between N_REQ sources.
// Optional stall-timeout release is enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
   import uart_tx_arb_pkg::*;
#(
   parameter int N_REQ       = DEF_N_REQ,
   parameter int MAX_PKT_LEN = DEF_MAX_PKT_LEN
`ifdef UART_TX_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cfg_en_i,
   input  logic [N_REQ-1:0]     req_valid_i,
   input  logic [8*N_REQ-1:0]   req_data_i,
   input  logic [N_REQ-1:0]     req_last_i,
   output logic [N_REQ-1:0]     req_ready_o,
   output logic [7:0]           tx_data_o,
   output logic                 tx_valid_o,
   input  logic                 tx_ready_i,
   input  logic                 tx_busy_i,
   output logic [N_REQ-1:0]     grant_o,
   output logic                 trunc_o
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_PKT_LEN - 1);
   localparam logic [PTR_W-1:0] TOP_IDX  = PTR_W'(N_REQ - 1);

   arb_state_e       state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [PTR_W-1:0] gidx_q, gidx_d;
   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam logic [CNT_W-1:0] STALL_IDX = CNT_W'(TIMEOUT_CYC - 1);
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
`endif

   logic [N_REQ-1:0] pick_grant;
   logic [PTR_W-1:0] pick_idx;
   logic             pick_found;

   rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .req_i   (req_valid_i),
      .ptr_i   (rr_ptr_q),
      .grant_o (pick_grant),
      .idx_o   (pick_idx),
      .found_o (pick_found)
   );

   logic             g_valid;
   logic             g_last;
   logic [7:0]       g_data;
   logic [PTR_W-1:0] g_next;

   assign g_valid = req_valid_i[gidx_q];
   assign g_last  = req_last_i[gidx_q];
   assign g_data  = req_data_i[8*gidx_q +: 8];
   assign g_next  = (gidx_q == TOP_IDX) ? '0 : gidx_q + 1'b1;
   assign grant_o = grant_q;

   always_comb begin
      logic xfer;
      state_d     = state_q;
      grant_d     = grant_q;
      gidx_d      = gidx_q;
      rr_ptr_d    = rr_ptr_q;
      byte_cnt_d  = byte_cnt_q;
      req_ready_o = '0;
      tx_valid_o  = 1'b0;
      tx_data_o   = '0;
      trunc_o     = 1'b0;
      xfer        = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      stall_cnt_d = stall_cnt_q;
`endif
      // Disable abandons any packet in flight but keeps fairness history.
      if (!cfg_en_i) begin
         state_d = IDLE;
         grant_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|req_valid_i) state_d = ARB;
            end
            ARB: begin
               if (pick_found) begin
                  grant_d    = pick_grant;
                  gidx_d     = pick_idx;
                  byte_cnt_d = '0;
                  state_d    = XFER;
`ifdef UART_TX_ARB_TIMEOUT_EN
                  stall_cnt_d = '0;
`endif
               end else begin
                  state_d = IDLE;
               end
            end
            XFER: begin
               tx_data_o           = g_data;
               tx_valid_o          = g_valid;
               req_ready_o[gidx_q] = tx_ready_i & g_valid;
               xfer                = g_valid & tx_ready_i;
               if (xfer) begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
                  stall_cnt_d = '0;
`endif
                  if (g_last || (byte_cnt_q == LAST_IDX)) begin
                     state_d  = DRAIN;
                     rr_ptr_d = g_next;
                     trunc_o  = ~g_last;
                  end
               end
`ifdef UART_TX_ARB_TIMEOUT_EN
               else if (!g_valid) begin
                  if (stall_cnt_q == STALL_IDX) begin
                     state_d     = DRAIN;
                     rr_ptr_d    = g_next;
                     trunc_o     = 1'b1;
                     stall_cnt_d = '0;
                  end else begin
                     stall_cnt_d = stall_cnt_q + 1'b1;
                  end
               end
`endif
            end
            DRAIN: begin
               if (tx_ready_i && !tx_busy_i) begin
                  grant_d = '0;
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
               grant_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst_i) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         gidx_q      <= '0;
         rr_ptr_q    <= '0;
         byte_cnt_q  <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
         stall_cnt_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         gidx_q      <= gidx_d;
         rr_ptr_q    <= rr_ptr_d;
         byte_cnt_q  <= byte_cnt_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
         stall_cnt_q <= stall_cnt_d;
`endif
      end
   end

endmodule : uart_tx_arbiter
